if_prefetch_unit: RTL and testbench

//   Instruction-fetch front end with a prefetch queue. Replaces the combinational PC->ROM lookup ahead of IF_ID.

---
 rtl/if_prefetch_unit_pkg.sv | 23 ++
 rtl/if_prefetch_unit_inst_fifo.sv | 62 ++++++
 rtl/if_prefetch_unit.sv | 118 +++++++++++
 tb/tb_if_prefetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types for the instruction-fetch prefetch unit: FSM states, FIFO entry
// layout and the NOP word presented to IF_ID when nothing has been fetched.
package if_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_unit_inst_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries. The head is read
// combinationally so IF_ID sees a new entry the cycle after it is pushed.
module inst_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t   mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  // A push while full is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != FULL_COUNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Flush wins over a simultaneous push so nothing from the old stream survives.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues sequential word fetches over a req/ack
// memory port, queues the results and hands {pc, inst} to IF_ID with valid/ready.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_e  state_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   target_reg;
  logic [31:0]   redirect_pc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redirect_pc = word_align(redirect_addr);
  assign pop         = out_valid && out_ready;
  assign push        = (state_reg == WAIT) && imem_ack && !redirect_en;
  assign next_count  = count + CW'(push) - CW'(pop);
  assign push_entry  = '{pc: fetch_pc_reg, inst: imem_rdata};

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_en),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= WAIT;
      fetch_pc_reg <= RESET_PC;
      target_reg   <= RESET_PC;
    end else if (redirect_en) begin
      unique case (state_reg)
        // An outstanding request must complete before the new target can be
        // fetched; its response is thrown away in DRAIN.
        WAIT, DRAIN: begin
          if (imem_ack) begin
            fetch_pc_reg <= redirect_pc;
            state_reg    <= WAIT;
          end else begin
            target_reg <= redirect_pc;
            state_reg  <= DRAIN;
          end
        end
        default: begin
          fetch_pc_reg <= redirect_pc;
          state_reg    <= WAIT;
        end
      endcase
    end else begin
      unique case (state_reg)
        IDLE: begin
          // No push happens in IDLE, so room exists unless full with no pop.
          if (!fifo_full || pop) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            state_reg    <= (next_count < FULL_COUNT) ? WAIT : IDLE;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            fetch_pc_reg <= target_reg;
            state_reg    <= WAIT;
          end
        end
        default: begin
          state_reg <= WAIT;
        end
      endcase
    end
  end

  // fetch_pc only moves on an ack, which keeps the address stable in DRAIN.
  assign imem_req  = (state_reg != IDLE);
  assign imem_addr = fetch_pc_reg;

  assign out_valid = !fifo_empty;
  assign out_inst  = fifo_empty ? NOP_INST : head.inst;
  assign out_pc    = fifo_empty ? 32'h0000_0000 : head.pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: a scoreboard of expected PCs is filled by
// the stimulus and drained by a monitor on every out_valid && out_ready.
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  bit          mem_en = 1'b0;
  int          mem_lat = 0;
  int          mem_wait = 0;
  int          ack_cnt = 0;
  bit          mem_pending = 1'b0;
  logic [31:0] mem_held = '0;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after mem_lat waiting cycles and checks that a pending
  // request keeps its address until it is acknowledged.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_wait    = 0;
        mem_pending = 1'b0;
        if (mem_en) imem_ack = 1'b0;
      end else begin
        if (mem_en) begin
          if (imem_req && mem_wait >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_wait   = 0;
            ack_cnt++;
          end else begin
            imem_ack = 1'b0;
            if (imem_req) mem_wait++;
            else mem_wait = 0;
          end
        end
        if (mem_pending) begin
          check("req_held", 32'(imem_req), 32'd1);
          check("addr_stable", imem_addr, mem_held);
        end
        mem_pending = imem_req && !imem_ack;
        mem_held    = imem_addr;
      end
    end
  end

  // Monitor: every accepted output must match the head of the scoreboard.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h expected no output", out_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          check("out_pc", out_pc, exp_pc);
          check("out_inst", out_inst, mem_word(exp_pc));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    mem_en = 1'b0;
    imem_ack = 1'b0;
    redirect_en = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, NOP_INST);
    check("rst_pc", out_pc, 32'd0);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    mem_en = 1'b0;
    imem_ack = 1'b0;
    redirect_en = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    check(name, sb_q.size(), 32'd0);
  endtask

  initial begin
    int ack_base;

    // Zero-wait memory streaming at one instruction per cycle.
    do_reset();
    mem_lat = 0; mem_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t1_req", 32'(imem_req), 32'd1);
      check("t1_addr", imem_addr, 32'(4 * i));
      check("t1_valid", 32'(out_valid), 32'(i >= 1));
      sb_q.push_back(32'(4 * i));
      step();
    end
    drain("t1_drained");

    // Back-pressure: FIFO fills with exactly DEPTH entries, one pop reopens issue.
    do_reset();
    mem_lat = 0; mem_en = 1'b1; out_ready = 1'b0;
    ack_base = ack_cnt;
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", imem_addr, 32'(4 * i));
      sb_q.push_back(32'(4 * i));
      step();
    end
    check("t2_full_req", 32'(imem_req), 32'd0);
    step();
    check("t2_full_req2", 32'(imem_req), 32'd0);
    check("t2_ack_count", 32'(ack_cnt - ack_base), 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_reopen_req", 32'(imem_req), 32'd1);
    check("t2_reopen_addr", imem_addr, 32'h10);
    sb_q.push_back(32'h10);
    step();
    check("t2_refull_req", 32'(imem_req), 32'd0);
    drain("t2_drained");

    // Redirect while a slow request is outstanding.
    do_reset();
    mem_lat = 3; mem_en = 1'b1; out_ready = 1'b1;
    check("t3_addr0", imem_addr, 32'h0);
    step();
    redirect_en = 1'b1; redirect_addr = 32'h200;
    step();
    redirect_en = 1'b0;
    check("t3_held_addr", imem_addr, 32'h0);
    step();
    check("t3_held_addr2", imem_addr, 32'h0);
    step();
    check("t3_empty_inst", out_inst, NOP_INST);
    sb_q.push_back(32'h200);
    for (int i = 0; i < 4; i++) begin
      check("t3_new_addr", imem_addr, 32'h200);
      check("t3_valid", 32'(out_valid), 32'd0);
      step();
    end
    check("t3_valid_after", 32'(out_valid), 32'd1);
    drain("t3_drained");

    // Redirect coinciding with an ack and a pop.
    do_reset();
    mem_lat = 0; mem_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_addr", imem_addr, 32'(4 * i));
      step();
    end
    out_ready = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h300;
    sb_q.push_back(32'h0);
    step();
    redirect_en = 1'b0;
    check("t4_flush_valid", 32'(out_valid), 32'd0);
    check("t4_target_addr", imem_addr, 32'h300);
    sb_q.push_back(32'h300);
    step();
    check("t4_valid", 32'(out_valid), 32'd1);
    drain("t4_drained");

    // Unaligned redirect near the top of memory, fetch wraps to zero.
    do_reset();
    mem_lat = 0; mem_en = 1'b1; out_ready = 1'b1;
    redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFB;
    step();
    redirect_en = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    sb_q.push_back(32'hFFFF_FFF8);
    step();
    check("t5_addr1", imem_addr, 32'hFFFF_FFFC);
    sb_q.push_back(32'hFFFF_FFFC);
    step();
    check("t5_addr2", imem_addr, 32'h0000_0000);
    sb_q.push_back(32'h0000_0000);
    step();
    drain("t5_drained");

    // Reset in the middle of DRAIN with a stale ack during reset.
    do_reset();
    out_ready = 1'b1;
    redirect_en = 1'b1; redirect_addr = 32'h400;
    step();
    redirect_en = 1'b0;
    check("t6_drain_addr", imem_addr, 32'h0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b1; imem_ack = 1'b0;
    check("t6_rel_req", 32'(imem_req), 32'd1);
    check("t6_rel_addr", imem_addr, 32'h0);
    check("t6_rel_valid", 32'(out_valid), 32'd0);
    step();
    check("t6_wait_valid", 32'(out_valid), 32'd0);
    mem_lat = 0; mem_en = 1'b1;
    sb_q.push_back(32'h0);
    step();
    check("t6_valid", 32'(out_valid), 32'd1);
    drain("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
